// File: rtl/encrypt_stream_if.sv
// Handshake bundle between an encrypt_stream block and its key/plaintext source
// and ciphertext sink.
interface encrypt_stream_if #(
    parameter int N = 30,
    parameter int P = 6
);
    logic         start;
    logic [P-1:0] plaintext;
    logic         pk_valid;
    logic [N-1:0] pk_a;
    logic [N-1:0] pk_b;
    logic         pk_ready;
    logic [N-1:0] cipher_text_top;
    logic [N-1:0] cipher_text_bot;
    logic         ct_valid;
    logic         ct_ready;
    logic         busy;

    modport master (
        output start, plaintext, pk_valid, pk_a, pk_b, ct_ready,
        input  pk_ready, cipher_text_top, cipher_text_bot, ct_valid, busy
    );

    modport slave (
        input  start, plaintext, pk_valid, pk_a, pk_b, ct_ready,
        output pk_ready, cipher_text_top, cipher_text_bot, ct_valid, busy
    );
endinterface

// File: rtl/encrypt_stream.sv
// Sequential LWE encryptor: sums an LFSR-selected subset of public-key rows and
// adds the scaled plaintext to the top word, then offers the ciphertext pair.
module encrypt_stream #(
    parameter int          N         = 30,
    parameter int          P         = 6,
    parameter int          ROWS      = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    encrypt_stream_if.slave bus
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam int          CW   = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

    state_t        state, next_state;
    logic [15:0]   lfsr;
    logic [CW-1:0] row_cnt;
    logic [P-1:0]  pt_q;
    logic [N-1:0]  acc_top, acc_bot;

    logic          accept;
    logic          last_row;
    logic          sel;
    logic [N-1:0]  pt_scaled;
    logic [N-1:0]  add_top, add_bot;

    assign accept    = (state == LOAD) && bus.pk_valid;
    assign last_row  = accept && (row_cnt == CW'(ROWS - 1));
    assign sel       = lfsr[0];
    assign pt_scaled = {pt_q, {(N-P){1'b0}}};
    assign add_bot   = sel ? bus.pk_a : '0;
    assign add_top   = (sel ? bus.pk_b : '0) + (last_row ? pt_scaled : '0);

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state   = state;
        bus.pk_ready = 1'b0;
        bus.ct_valid = 1'b0;
        unique case (state)
            IDLE: if (bus.start) next_state = LOAD;
            LOAD: begin
                bus.pk_ready = 1'b1;
                if (last_row) next_state = OUT;
            end
            OUT: begin
                bus.ct_valid = 1'b1;
                if (bus.ct_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: all datapath registers are reset, so a reset mid-message leaves no
    // partial ciphertext visible on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= SEED;
            row_cnt <= '0;
            pt_q    <= '0;
            acc_top <= '0;
            acc_bot <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                pt_q    <= bus.plaintext;
                row_cnt <= '0;
                acc_top <= '0;
                acc_bot <= '0;
            end else if (accept) begin
                acc_top <= acc_top + add_top;
                acc_bot <= acc_bot + add_bot;
                lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                row_cnt <= row_cnt + CW'(1);
            end
        end
    end

    assign bus.cipher_text_top = acc_top;
    assign bus.cipher_text_bot = acc_bot;
    assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_encrypt_stream.sv
// Scoreboard bench for encrypt_stream: drivers push expected ciphertexts, per-DUT
// monitors pop and compare on each ct_valid/ct_ready handshake.
module tb_encrypt_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encrypt_stream_if #(.N(30), .P(6)) ifa ();
    encrypt_stream_if #(.N(30), .P(6)) ifb ();

    encrypt_stream #(.N(30), .P(6), .ROWS(4), .LFSR_SEED(16'hFFFF)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    encrypt_stream #(.N(30), .P(6), .ROWS(16), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    typedef struct packed {
        logic [29:0] top;
        logic [29:0] bot;
    } ct_t;

    ct_t q_a[$];
    ct_t q_b[$];
    int  checks   = 0;
    int  failures = 0;
    logic [29:0] row_a [4];
    logic [29:0] row_b [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_compare(input string tag, input logic [29:0] top, input logic [29:0] bot,
                               inout ct_t q[$]);
        ct_t e;
        if (q.size() == 0) begin
            check({tag, " unexpected ct"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            check({tag, " top"}, 64'(top), 64'(e.top));
            check({tag, " bot"}, 64'(bot), 64'(e.bot));
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n && ifa.ct_valid && ifa.ct_ready)
            mon_compare("a", ifa.cipher_text_top, ifa.cipher_text_bot, q_a);
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n && ifb.ct_valid && ifb.ct_ready)
            mon_compare("b", ifb.cipher_text_top, ifb.cipher_text_bot, q_b);
    end

    // One message through dut_a; gap toggles pk_valid, stall holds ct_ready low
    // for that many ct_valid cycles, inject pulses start with plaintext 63.
    task automatic run_a(input string name, input logic [5:0] pt, input bit gap,
                         input int stall, input int inject, input int exp_lat,
                         input logic [29:0] exp_top, input logic [29:0] exp_bot);
        int  idx = 0;
        int  vcyc = 0;
        int  lat = -1;
        bit  done = 1'b0;
        ct_t e;
        e.top = exp_top;
        e.bot = exp_bot;
        q_a.push_back(e);
        for (int cycle = 0; cycle < 200 && !done; cycle++) begin
            @(negedge clk);
            ifa.start     = (cycle == 0) || (cycle == inject);
            ifa.plaintext = (cycle == 0) ? pt : 6'd63;
            ifa.pk_valid  = gap ? (cycle % 2 == 0) : 1'b1;
            ifa.pk_a      = (idx < 4) ? row_a[idx] : 30'd0;
            ifa.pk_b      = (idx < 4) ? row_b[idx] : 30'd0;
            if (ifa.ct_valid) begin
                if (lat < 0) lat = cycle;
                if (vcyc < stall) begin
                    check({name, " stall top"}, 64'(ifa.cipher_text_top), 64'(exp_top));
                    check({name, " stall bot"}, 64'(ifa.cipher_text_bot), 64'(exp_bot));
                end
                ifa.ct_ready = (vcyc >= stall);
                vcyc++;
            end else begin
                ifa.ct_ready = (stall == 0);
            end
            if (ifa.pk_valid && ifa.pk_ready) idx++;
            if (ifa.ct_valid && ifa.ct_ready) done = 1'b1;
        end
        @(negedge clk);
        ifa.start    = 1'b0;
        ifa.pk_valid = 1'b0;
        ifa.ct_ready = 1'b1;
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " rows"}, 64'(idx), 64'd4);
        check({name, " idle after"}, 64'(ifa.busy), 64'd0);
    endtask

    initial begin
        logic [15:0] m;
        logic [29:0] bot_ref;
        int  lat_b;
        bit  done_b;
        ct_t eb;

        ifa.start = 0; ifa.plaintext = 0; ifa.pk_valid = 0; ifa.pk_a = 0; ifa.pk_b = 0; ifa.ct_ready = 1;
        ifb.start = 0; ifb.plaintext = 0; ifb.pk_valid = 0; ifb.pk_a = 0; ifb.pk_b = 0; ifb.ct_ready = 1;

        #1;
        check("reset top", 64'(ifa.cipher_text_top), 64'd0);
        check("reset bot", 64'(ifa.cipher_text_bot), 64'd0);
        check("reset busy", 64'(ifa.busy), 64'd0);
        check("reset pk_ready", 64'(ifa.pk_ready), 64'd0);
        check("reset ct_valid", 64'(ifa.ct_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Seed FFFF gives r=1 for the first 16 rows: tests 1..4 use exactly those.
        row_a = '{30'd1, 30'd2, 30'd3, 30'd4};
        row_b = '{30'd10, 30'd20, 30'd30, 30'd40};
        run_a("basic", 6'd5, 1'b0, 0, -1, 5, 30'd83886180, 30'd10);

        row_a = '{30'd0, 30'd0, 30'd0, 30'd0};
        row_b = '{30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF};
        run_a("wrap", 6'd0, 1'b0, 0, -1, 5, 30'd1073741820, 30'd0);

        row_a = '{30'd1, 30'd2, 30'd3, 30'd4};
        row_b = '{30'd10, 30'd20, 30'd30, 30'd40};
        run_a("gap_stall", 6'd5, 1'b1, 5, -1, 9, 30'd83886180, 30'd10);
        run_a("start_in_load", 6'd5, 1'b0, 0, 2, 5, 30'd83886180, 30'd10);

        // Reset after two accepted rows: partial sums must vanish immediately.
        @(negedge clk);
        ifa.start = 1'b1; ifa.plaintext = 6'd5; ifa.pk_valid = 1'b1;
        ifa.pk_a = 30'd1; ifa.pk_b = 30'd10;
        @(negedge clk);
        ifa.start = 1'b0;
        @(negedge clk);
        ifa.pk_a = 30'd2; ifa.pk_b = 30'd20;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset top", 64'(ifa.cipher_text_top), 64'd0);
        check("midreset bot", 64'(ifa.cipher_text_bot), 64'd0);
        check("midreset busy", 64'(ifa.busy), 64'd0);
        check("midreset ct_valid", 64'(ifa.ct_valid), 64'd0);
        check("midreset pk_ready", 64'(ifa.pk_ready), 64'd0);
        ifa.pk_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_a("after_reset", 6'd5, 1'b0, 0, -1, 5, 30'd83886180, 30'd10);

        // dut_b: pk_a=2^i selects r bits into bot; for seed ACE1 the first 16 r
        // bits are the seed bits themselves, so bot = 16'hACE1 = 44257.
        m = 16'hACE1;
        bot_ref = '0;
        for (int i = 0; i < 16; i++) begin
            bot_ref[i] = m[0];
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
        check("ref model ace1", 64'(bot_ref), 64'd44257);
        eb.top = 30'd0;
        eb.bot = bot_ref;
        q_b.push_back(eb);
        lat_b = -1;
        done_b = 1'b0;
        begin
            int idx = 0;
            for (int cycle = 0; cycle < 200 && !done_b; cycle++) begin
                @(negedge clk);
                ifb.start     = (cycle == 0);
                ifb.plaintext = 6'd0;
                ifb.pk_valid  = 1'b1;
                ifb.pk_a      = (idx < 16) ? (30'd1 << idx) : 30'd0;
                ifb.pk_b      = 30'd0;
                if (ifb.ct_valid && lat_b < 0) lat_b = cycle;
                if (ifb.pk_valid && ifb.pk_ready) idx++;
                if (ifb.ct_valid && ifb.ct_ready) done_b = 1'b1;
            end
            @(negedge clk);
            ifb.pk_valid = 1'b0;
            check("b rows", 64'(idx), 64'd16);
        end
        check("b done", 64'(done_b), 64'd1);
        check("b latency", 64'(lat_b), 64'd17);

        repeat (3) @(negedge clk);
        check("a queue drained", 64'(q_a.size()), 64'd0);
        check("b queue drained", 64'(q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encrypt_stream.md
# encrypt_stream

Sequential LWE public-key encryptor that produces the (cipher_text_top, cipher_text_bot) pair consumed by the team's decryption block. It latches a P-bit plaintext on `start` and streams ROWS public-key rows (pk_a, pk_b) through a valid/ready handshake. An internal LFSR selects a random subset of rows, and the selected rows are accumulated modulo 2^N. The scaled plaintext is added to the top accumulator, and the ciphertext is presented on a valid/ready output port.

## Interface
- N, 30: ciphertext/key word width; all arithmetic modulo 2^N
- P, 6: plaintext width
- ROWS, 16: public-key rows consumed per encryption (>=1)
- LFSR_SEED, 16'hACE1: 16-bit LFSR reset value; 0 is replaced by 16'hACE1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin encryption (sampled in IDLE only)
- plaintext  in  P  message, latched on accepted start
- pk_valid  in  1  public-key row present
- pk_a  in  N  row coefficient a_i
- pk_b  in  N  row value b_i (= -s*a_i + e_i)
- pk_ready  out  1  block accepts a row this cycle
- cipher_text_top  out  N  signed two's-complement ciphertext top word
- cipher_text_bot  out  N  signed two's-complement ciphertext bottom word
- ct_valid  out  1  ciphertext valid
- ct_ready  in  1  downstream accepts ciphertext
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, LOAD, OUT.
- IDLE: pk_ready=0, ct_valid=0. If start=1, the block:
  - latches plaintext,
  - clears both accumulators and the row counter,
  - moves to LOAD.
- LOAD: pk_ready=1.
  - Each pk_valid&pk_ready is one accepted row. Let r = lfsr[0].
  - If r=1: acc_bot += pk_a and acc_top += pk_b, both mod 2^N. If r=0: accumulators are unchanged.
  - The LFSR advances and the row counter increments.
- LFSR: 16-bit Fibonacci, right shift. new msb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5] (x^16+x^14+x^13+x^11+1).
  - Advances only on accepted rows.
  - Not reseeded between messages; reseeded only by reset.
- On the accepted row that makes the counter reach ROWS:
  - acc_top additionally gets plaintext<<(N-P) added in the same update, mod 2^N.
  - State moves to OUT.
- OUT: ct_valid=1; outputs show the accumulators. On ct_valid&ct_ready the block returns to IDLE.
- cipher_text_top/bot always drive the accumulator registers. They are meaningful only while ct_valid=1 and hold stable until the handshake.
- start while busy=1 is ignored; the latched plaintext is unchanged.
- pk_valid outside LOAD is ignored (pk_ready=0).
- Row counter width: $clog2(ROWS+1).

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - pk_ready=0, ct_valid=0, busy=0
  - cipher_text_top=0, cipher_text_bot=0
  - lfsr=seed, counter=0, latched plaintext=0
- Start accepted at edge T. pk_ready=1 from cycle T+1.
- With pk_valid held high: rows accepted at edges T+1..T+ROWS, and ct_valid rises after edge T+ROWS. Total start-to-valid latency is ROWS+1 cycles.
- pk_valid gaps stretch latency one cycle per idle cycle. No row is lost or duplicated.
- ct_ready low holds OUT indefinitely. Outputs, LFSR and counter are frozen.
- ct_ready high in the first OUT cycle gives one-cycle ct_valid; IDLE is entered the next cycle.
- Start may be re-asserted in the first IDLE cycle after the handshake. Minimum spacing between ciphertexts is ROWS+2 cycles.
- rst_n low at any time (mid-LOAD or mid-OUT):
  - immediately forces all reset values,
  - discards the partial ciphertext,
  - emits no ct_valid.
- Overflow wraps silently modulo 2^N. There is no saturation and no flag.

## Test plan
- ROWS=4, LFSR_SEED=16'hFFFF (first 16 r bits all 1), N=30, P=6. pk_a=1,2,3,4; pk_b=10,20,30,40; plaintext=5; ct_ready=1 -> ct_valid at start+5 cycles; bot=10; top=100+5*2^24=83886180.
- Same setup, each pk_b=2^30-1, pk_a=0, plaintext=0 -> top=1073741820 (wrap), bot=0.
- Same data as the first test, with pk_valid toggled 1,0,1,0,... and ct_ready held low 5 cycles -> same values as the first test; ct_valid asserted at start+9 cycles; outputs stable throughout the 5 stalled cycles; exactly 4 rows accepted.
- Start pulsed during LOAD with plaintext=63 -> ignored; result still uses plaintext=5.
- rst_n pulsed low after 2 accepted rows -> all outputs 0 within the reset cycle. After release, rerunning the first test yields identical values, proving LFSR reseed.
- Default seed 16'hACE1, ROWS=16, pk_a=2^i and pk_b=0 for i=0..15 -> bot equals the LFSR r-bit sequence packed LSB-first, checked against a reference LFSR model.
